// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for DataMem: latches one request, drives the memory, sequences sub-word stores.
// Optional: define DMEM_ARB_RR_EN for round-robin arbitration (default: fixed priority to port 0).
module dmem_arbiter #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_0,
    input  logic                 we_0,
    input  logic [addrWidth-1:0] addr_0,
    input  logic [dataWidth-1:0] wdata_0,
    input  logic [2:0]           memOp_0,
    output logic                 gnt_0,
    output logic                 rvalid_0,
    output logic [dataWidth-1:0] rdata_0,
    input  logic                 req_1,
    input  logic                 we_1,
    input  logic [addrWidth-1:0] addr_1,
    input  logic [dataWidth-1:0] wdata_1,
    input  logic [2:0]           memOp_1,
    output logic                 gnt_1,
    output logic                 rvalid_1,
    output logic [dataWidth-1:0] rdata_1,
    output logic [addrWidth-1:0] mem_addr,
    output logic [dataWidth-1:0] mem_din,
    output logic [2:0]           mem_memOp,
    output logic                 mem_we,
    input  logic [dataWidth-1:0] mem_dout,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, PRIME, WRITE, RESP} state_t;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic                 port_q, port_d;
    logic [2:0]           op_q, op_d;
    logic [addrWidth-1:0] addr_q, addr_d;
    logic [dataWidth-1:0] din_q, din_d;

    logic                 accept, pick_1;
    logic                 sel_we, sel_sub;
    logic [addrWidth-1:0] sel_addr;
    logic [dataWidth-1:0] sel_wdata;
    logic [2:0]           sel_op;
    logic                 op_legal;

`ifdef DMEM_ARB_RR_EN
    // rr_q names the port that wins when both request
    logic rr_q, rr_d;

    always_comb begin
        pick_1 = req_1 && (!req_0 || rr_q);
        rr_d   = rr_q;
        if (accept) rr_d = !pick_1;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`else
    always_comb pick_1 = req_1 && !req_0;
`endif

    // Request selection and acceptance window
    always_comb begin
        accept    = !rst && (state_q == IDLE || state_q == RESP) && (req_0 || req_1);
        sel_we    = pick_1 ? we_1    : we_0;
        sel_addr  = pick_1 ? addr_1  : addr_0;
        sel_wdata = pick_1 ? wdata_1 : wdata_0;
        sel_op    = pick_1 ? memOp_1 : memOp_0;
        sel_sub   = sel_we && (sel_op == OP_B || sel_op == OP_H);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            port_q  <= 1'b0;
            op_q    <= OP_W;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            port_q  <= port_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        port_d  = port_q;
        op_d    = op_q;
        addr_d  = addr_q;
        din_d   = din_q;
        unique case (state_q)
            IDLE, RESP: state_d = accept ? (sel_sub ? PRIME : ISSUE) : IDLE;
            ISSUE:      state_d = we_q ? IDLE : RESP;
            PRIME:      state_d = WRITE;
            WRITE:      state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if (accept) begin
            we_d   = sel_we;
            port_d = pick_1;
            op_d   = sel_op;
            addr_d = sel_addr;
            din_d  = sel_wdata;
        end
    end

    always_comb begin
        unique case (op_q)
            OP_B, OP_H, OP_W, OP_BU, OP_HU: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    end

    // Illegal-op stores pass through ISSUE without a write strobe
    always_comb begin
        gnt_0     = accept && !pick_1;
        gnt_1     = accept && pick_1;
        busy      = (state_q != IDLE);
        mem_we    = (state_q == ISSUE && we_q && op_q == OP_W) || (state_q == WRITE);
        mem_addr  = addr_q;
        mem_din   = din_q;
        mem_memOp = op_q;
        rvalid_0  = (state_q == RESP) && !port_q;
        rvalid_1  = (state_q == RESP) && port_q;
        rdata_0   = (rvalid_0 && op_legal) ? mem_dout : '0;
        rdata_1   = (rvalid_1 && op_legal) ? mem_dout : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a DataMem model and a byte-level reference memory.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst, mem_clr;
    logic        req_0, we_0, req_1, we_1;
    logic [31:0] addr_0, wdata_0, addr_1, wdata_1;
    logic [2:0]  memOp_0, memOp_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1, mem_we, busy;
    logic [31:0] rdata_0, rdata_1, mem_addr, mem_din;
    logic [2:0]  mem_memOp;
    logic [31:0] mem_dout;

    int n_chk = 0;
    int n_err = 0;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.addrWidth(32), .dataWidth(32)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .memOp_0(memOp_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .memOp_1(memOp_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_memOp(mem_memOp), .mem_we(mem_we),
        .mem_dout(mem_dout), .busy(busy)
    );

    // DataMem model: registered read, sub-word writes merge into the word read the cycle before
    logic [7:0]  mem_b [0:1023];
    logic [31:0] prime_q, m_word, m_sh, m_rd, m_merge;
    logic [9:0]  m_wa;

    always_comb begin
        m_wa   = {mem_addr[9:2], 2'b00};
        m_word = {mem_b[m_wa + 10'd3], mem_b[m_wa + 10'd2], mem_b[m_wa + 10'd1], mem_b[m_wa]};
        m_sh   = m_word >> {mem_addr[1:0], 3'b000};
        case (mem_memOp)
            3'b000:  m_rd = {{24{m_sh[7]}}, m_sh[7:0]};
            3'b100:  m_rd = {24'h0, m_sh[7:0]};
            3'b001:  m_rd = {{16{m_sh[15]}}, m_sh[15:0]};
            3'b101:  m_rd = {16'h0, m_sh[15:0]};
            default: m_rd = m_word;
        endcase
        m_merge = mem_din;
        if (mem_memOp == 3'b000) begin
            m_merge = prime_q;
            m_merge[{mem_addr[1:0], 3'b000} +: 8] = mem_din[7:0];
        end else if (mem_memOp == 3'b001) begin
            m_merge = prime_q;
            m_merge[{mem_addr[1], 4'b0000} +: 16] = mem_din[15:0];
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem_b[i] <= 8'h0;
            mem_dout <= 32'h0;
            prime_q  <= 32'h0;
        end else if (mem_we) begin
            mem_b[m_wa]         <= m_merge[7:0];
            mem_b[m_wa + 10'd1] <= m_merge[15:8];
            mem_b[m_wa + 10'd2] <= m_merge[23:16];
            mem_b[m_wa + 10'd3] <= m_merge[31:24];
        end else begin
            prime_q  <= m_word;
            mem_dout <= m_rd;
        end
    end

    // Reference model: little-endian byte array plus the priority pointer
    logic [7:0] ref_b [0:1023];
    logic       rr_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
        int i;
        logic [7:0]  b;
        logic [15:0] h;
        i = int'(a[9:0]);
        b = ref_b[i];
        h = {ref_b[i+1], ref_b[i]};
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            3'b010:  return {ref_b[i+3], ref_b[i+2], h};
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        int i;
        i = int'(a[9:0]);
        case (op)
            3'b010: for (int k = 0; k < 4; k++) ref_b[i+k] = d[8*k +: 8];
            3'b001: begin ref_b[i] = d[7:0]; ref_b[i+1] = d[15:8]; end
            3'b000: ref_b[i] = d[7:0];
            default: ;
        endcase
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] op);
        if (p == 0) begin req_0 = r; we_0 = w; addr_0 = a; wdata_0 = d; memOp_0 = op; end
        else        begin req_1 = r; we_1 = w; addr_1 = a; wdata_1 = d; memOp_1 = op; end
    endtask

    // One transaction from an accept-capable cycle; ends on the last cycle of the operation
    task automatic do_op(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] op);
        int   waited;
        logic g, sub, word;
        drive(p, 1'b1, w, a, d, op);
        #1;
        waited = 0;
        g = (p != 0) ? gnt_1 : gnt_0;
        while (!g && waited < 20) begin
            @(negedge clk); #1;
            waited++;
            g = (p != 0) ? gnt_1 : gnt_0;
        end
        if (!g) begin
            chk("gnt_timeout", 32'd0, 32'd1);
            drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
            return;
        end
        chk("gnt_wait", 32'(waited), 32'd0);
        chk("gnt_other", 32'((p != 0) ? gnt_0 : gnt_1), 32'd0);
        rr_ptr = RR_EN && (p == 0);
        sub  = w && (op == 3'b000 || op == 3'b001);
        word = w && (op == 3'b010);
        @(negedge clk);
        drive(p, 1'b0, 1'($urandom), $urandom, $urandom, 3'($urandom));
        #1;
        chk("busy_t1", 32'(busy), 32'd1);
        chk("addr_t1", mem_addr, a);
        chk("op_t1", 32'(mem_memOp), 32'(op));
        chk("we_t1", 32'(mem_we), 32'(word));
        if (w) chk("din_t1", mem_din, d);
        @(negedge clk); #1;
        if (!w) begin
            chk("rvalid", 32'((p != 0) ? rvalid_1 : rvalid_0), 32'd1);
            chk("rvalid_other", 32'((p != 0) ? rvalid_0 : rvalid_1), 32'd0);
            chk("rdata", (p != 0) ? rdata_1 : rdata_0, ref_load(a, op));
            chk("we_resp", 32'(mem_we), 32'd0);
        end else if (sub) begin
            chk("we_write", 32'(mem_we), 32'd1);
            chk("addr_write", mem_addr, a);
            @(negedge clk); #1;
            chk("busy_end", 32'(busy), 32'd0);
        end else begin
            chk("we_end", 32'(mem_we), 32'd0);
            chk("busy_end", 32'(busy), 32'd0);
        end
        ref_store(a, w ? d : 32'h0, w ? op : 3'b111);
    endtask

    logic [2:0] st_ops [3] = '{3'b000, 3'b001, 3'b010};
    logic [2:0] ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] bad_st [5] = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [2:0] bad_ld [3] = '{3'b011, 3'b110, 3'b111};

    initial begin
        int   win, last_win, rp;
        logic eg0, eg1, rw;
        logic [2:0]  rop;
        logic [31:0] ra;
        for (int i = 0; i < 1024; i++) ref_b[i] = 8'h0;
        rr_ptr = 1'b0;
        last_win = 0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        rst = 1'b1; mem_clr = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt0", 32'(gnt_0), 32'd0);
        chk("rst_gnt1", 32'(gnt_1), 32'd0);
        chk("rst_rvalid0", 32'(rvalid_0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid_1), 32'd0);
        chk("rst_rdata0", rdata_0, 32'h0);
        chk("rst_rdata1", rdata_1, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        chk("rst_mem_op", 32'(mem_memOp), 32'h2);
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);

        // word store / load, then sub-word store and extending loads
        do_op(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
        do_op(0, 1'b0, 32'h100, 32'h0, 3'b010);
        do_op(0, 1'b1, 32'h101, 32'h00000055, 3'b000);
        do_op(0, 1'b0, 32'h100, 32'h0, 3'b010);
        chk("sb_merge", rdata_0, 32'hDEAD55EF);
        do_op(0, 1'b0, 32'h101, 32'h0, 3'b100);
        do_op(0, 1'b0, 32'h103, 32'h0, 3'b000);
        chk("lb_sign", rdata_0, 32'hFFFFFFDE);
        // illegal-op store and load
        do_op(1, 1'b1, 32'h100, 32'h12345678, 3'b111);
        do_op(1, 1'b0, 32'h100, 32'h0, 3'b010);
        do_op(1, 1'b0, 32'h100, 32'h0, 3'b110);

        // reset during PRIME of a halfword store
        do_op(0, 1'b1, 32'h200, 32'hCAFEF00D, 3'b010);
        drive(0, 1'b1, 1'b1, 32'h200, 32'h0000BEEF, 3'b001);
        #1;
        chk("sh_gnt", 32'(gnt_0), 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        rst = 1'b1;
        #1;
        chk("prime_we", 32'(mem_we), 32'd0);
        chk("prime_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        rr_ptr = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        @(negedge clk); #1;
        chk("rst_mid_we2", 32'(mem_we), 32'd0);
        do_op(0, 1'b0, 32'h200, 32'h0, 3'b010);
        chk("rst_mid_word", rdata_0, 32'hCAFEF00D);

        // both ports hold loads; accept slots every second cycle
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
        drive(1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin
                drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
                drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
            end
            #1;
            eg0 = 1'b0; eg1 = 1'b0; win = 0;
            if (c % 2 == 0 && c < 6) begin
                win = int'(rr_ptr);
                eg0 = (win == 0); eg1 = (win == 1);
                rr_ptr = RR_EN && (win == 0);
            end
            chk("cont_gnt0", 32'(gnt_0), 32'(eg0));
            chk("cont_gnt1", 32'(gnt_1), 32'(eg1));
            if (c >= 2 && c % 2 == 0) begin
                chk("cont_rvalid", 32'((last_win != 0) ? rvalid_1 : rvalid_0), 32'd1);
                chk("cont_rdata", (last_win != 0) ? rdata_1 : rdata_0,
                    ref_load((last_win != 0) ? 32'h200 : 32'h100, 3'b010));
            end
            if (eg0 || eg1) last_win = win;
            @(negedge clk);
        end

        // randomized single-port traffic
        for (int n = 0; n < 60; n++) begin
            rp = int'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                rop = rw ? bad_st[$urandom_range(0, 4)] : bad_ld[$urandom_range(0, 2)];
            else
                rop = rw ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
            ra = 32'($urandom_range(0, 15)) * 32'd4;
            if (rop == 3'b000 || rop == 3'b100)      ra = ra + 32'($urandom_range(0, 3));
            else if (rop == 3'b001 || rop == 3'b101) ra = ra + 32'd2 * 32'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(rp, rw, ra, $urandom, rop);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
